// File: rtl/pipe_ctrl.sv
// Pipeline hazard/interrupt controller: stalls, flushes, memory-wait freeze,
// interrupt drain sequencing and trap entry for a 5-stage pipeline.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LW_STALL,
  input  logic        BR_TAKEN,
  input  logic        MEM_BUSY,
  input  logic        INTR,
  input  logic        INTR_EN,
  input  logic [31:0] DEC_PC,
  output logic        PC_WE,
  output logic        IF_DEC_WE,
  output logic        DEC_EX_WE,
  output logic        EX_MEM_WE,
  output logic        MEM_WB_WE,
  output logic        IF_FLUSH,
  output logic        DEC_FLUSH,
  output logic        EX_FLUSH,
  output logic        INTR_TAKEN,
  output logic [31:0] EPC,
  output logic        MEM_ERR,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_TRAP     = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t      state, next_state;
  logic        ret, next_ret;
  logic [7:0]  wcnt, next_wcnt;
  logic [2:0]  dcnt, next_dcnt;
  logic [31:0] next_epc;
  logic        next_err;
  logic        use_run, use_drain, allow_intr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_RUN;
      ret     <= 1'b0;
      wcnt    <= 8'd0;
      dcnt    <= 3'd0;
      EPC     <= 32'd0;
      MEM_ERR <= 1'b0;
    end else begin
      state   <= next_state;
      ret     <= next_ret;
      wcnt    <= next_wcnt;
      dcnt    <= next_dcnt;
      EPC     <= next_epc;
      MEM_ERR <= next_err;
    end
  end

  always_comb begin
    PC_WE      = 1'b1;
    IF_DEC_WE  = 1'b1;
    DEC_EX_WE  = 1'b1;
    EX_MEM_WE  = 1'b1;
    MEM_WB_WE  = 1'b1;
    IF_FLUSH   = 1'b0;
    DEC_FLUSH  = 1'b0;
    EX_FLUSH   = 1'b0;
    INTR_TAKEN = 1'b0;
    next_state = state;
    next_ret   = ret;
    next_wcnt  = wcnt;
    next_dcnt  = dcnt;
    next_epc   = EPC;
    next_err   = MEM_ERR;
    use_run    = 1'b0;
    use_drain  = 1'b0;
    allow_intr = 1'b0;

    // A MEM_WAIT that sees the memory ready replays the rules of the state it froze (ret=1 means DRAIN)
    case (state)
      S_RUN: begin
        use_run    = 1'b1;
        allow_intr = 1'b1;
      end
      S_MEM_WAIT: begin
        if (MEM_BUSY) begin
          {PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE} = 5'b0;
          if (wcnt != 8'hFF) next_wcnt = wcnt + 8'd1;
          if (wcnt == WAIT_LAST) next_err = 1'b1;
        end else if (ret) begin
          use_drain = 1'b1;
        end else begin
          use_run = 1'b1;
        end
      end
      S_DRAIN: use_drain = 1'b1;
      S_TRAP: begin
        INTR_TAKEN = 1'b1;
        IF_FLUSH   = 1'b1;
        DEC_FLUSH  = 1'b1;
        next_state = S_RUN;
      end
      default: next_state = S_RUN;
    endcase

    if (use_run) begin
      next_state = S_RUN;
      if (MEM_BUSY) begin
        {PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE} = 5'b0;
        next_state = S_MEM_WAIT;
        next_ret   = 1'b0;
        next_wcnt  = 8'd0;
      end else if (BR_TAKEN) begin
        IF_FLUSH  = 1'b1;
        DEC_FLUSH = 1'b1;
      end else if (LW_STALL) begin
        {PC_WE, IF_DEC_WE, DEC_EX_WE} = 3'b0;
        EX_FLUSH = 1'b1;
      end else if (allow_intr && INTR && INTR_EN) begin
        PC_WE      = 1'b0;
        IF_FLUSH   = 1'b1;
        DEC_FLUSH  = 1'b1;
        next_epc   = DEC_PC;
        next_dcnt  = 3'd0;
        next_state = S_DRAIN;
      end
    end

    if (use_drain) begin
      if (MEM_BUSY) begin
        {PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE} = 5'b0;
        next_state = S_MEM_WAIT;
        next_ret   = 1'b1;
        next_wcnt  = 8'd0;
      end else begin
        PC_WE      = 1'b0;
        IF_FLUSH   = 1'b1;
        DEC_FLUSH  = 1'b1;
        next_dcnt  = dcnt + 3'd1;
        next_state = (dcnt == DRAIN_LAST) ? S_TRAP : S_DRAIN;
      end
    end

    // Reset forces a full freeze with bubbles everywhere, whatever the state
    if (RST) begin
      {PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE} = 5'b0;
      IF_FLUSH   = 1'b1;
      DEC_FLUSH  = 1'b1;
      EX_FLUSH   = 1'b1;
      INTR_TAKEN = 1'b0;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 15;

  logic        CLK = 1'b0;
  logic        RST, LW_STALL, BR_TAKEN, MEM_BUSY, INTR, INTR_EN;
  logic [31:0] DEC_PC;
  logic        PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE;
  logic        IF_FLUSH, DEC_FLUSH, EX_FLUSH, INTR_TAKEN, MEM_ERR;
  logic [31:0] EPC;
  logic [1:0]  STATE;

  int checks = 0;
  int passed = 0;

  // Model: waiting on memory, drain cycles still owed, trap due, busy-cycle count
  bit        m_wait  = 0;
  int        m_left  = 0;
  bit        m_trap  = 0;
  int        m_busy  = 0;
  bit        m_err   = 0;
  bit [31:0] m_epc   = 0;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .LW_STALL(LW_STALL), .BR_TAKEN(BR_TAKEN),
    .MEM_BUSY(MEM_BUSY), .INTR(INTR), .INTR_EN(INTR_EN), .DEC_PC(DEC_PC),
    .PC_WE(PC_WE), .IF_DEC_WE(IF_DEC_WE), .DEC_EX_WE(DEC_EX_WE),
    .EX_MEM_WE(EX_MEM_WE), .MEM_WB_WE(MEM_WB_WE), .IF_FLUSH(IF_FLUSH),
    .DEC_FLUSH(DEC_FLUSH), .EX_FLUSH(EX_FLUSH), .INTR_TAKEN(INTR_TAKEN),
    .EPC(EPC), .MEM_ERR(MEM_ERR), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Expected {PC_WE,IF_DEC_WE,DEC_EX_WE,EX_MEM_WE,MEM_WB_WE,IF_FLUSH,DEC_FLUSH,EX_FLUSH,INTR_TAKEN}
  function automatic logic [8:0] expCtrl();
    if (RST)                          return 9'b00000_111_0;
    if (m_trap)                       return 9'b11111_110_1;
    if (MEM_BUSY)                     return 9'b00000_000_0;
    if (m_left > 0)                   return 9'b01111_110_0;
    if (BR_TAKEN)                     return 9'b11111_110_0;
    if (LW_STALL)                     return 9'b00011_001_0;
    if (!m_wait && INTR && INTR_EN)   return 9'b01111_110_0;
    return 9'b11111_000_0;
  endfunction

  function automatic logic [1:0] expState();
    if (m_trap)     return 2'd3;
    if (m_wait)     return 2'd1;
    if (m_left > 0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic checkOutput();
    checkVal("ctrl", 32'({PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE,
                          IF_FLUSH, DEC_FLUSH, EX_FLUSH, INTR_TAKEN}), 32'(expCtrl()));
    checkVal("state", 32'(STATE), 32'(expState()));
    checkVal("epc", EPC, m_epc);
    checkVal("mem_err", 32'(MEM_ERR), 32'(m_err));
  endtask

  task automatic modelUpdate();
    bit was_wait;
    was_wait = m_wait;
    if (RST) begin
      m_wait = 0; m_left = 0; m_trap = 0; m_busy = 0; m_err = 0; m_epc = 0;
    end else if (m_trap) begin
      m_trap = 0;
    end else if (MEM_BUSY) begin
      if (!m_wait) begin
        m_wait = 1;
        m_busy = 0;
      end else begin
        m_busy++;
        if (m_busy == MEM_TIMEOUT) m_err = 1;
      end
    end else begin
      m_wait = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_trap = 1;
      end else if (!was_wait && !BR_TAKEN && !LW_STALL && INTR && INTR_EN) begin
        m_epc  = DEC_PC;
        m_left = DRAIN_CYCLES;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, busy, br, lw, intr, en, input logic [31:0] pc);
    RST = rst; MEM_BUSY = busy; BR_TAKEN = br; LW_STALL = lw;
    INTR = intr; INTR_EN = en; DEC_PC = pc;
    #1;
    checkOutput();
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    bit busy_lvl;
    RST = 1; MEM_BUSY = 0; BR_TAKEN = 0; LW_STALL = 0; INTR = 0; INTR_EN = 0; DEC_PC = 0;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);

    applyStimulus(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF);
    idle(3);

    applyStimulus(0, 0, 1, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 1, 1, 32'h44);
    applyStimulus(0, 0, 1, 0, 1, 1, 32'h48);
    idle(1);

    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0120);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 1, 1, 32'h0000_0200);
    idle(2);
    checkVal("epc_after_trap", EPC, 32'h0000_0120);

    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    idle(3);
    checkVal("mem_err_sticky", 32'(MEM_ERR), 32'd1);

    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0300);
    idle(1);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    idle(5);

    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0400);
    idle(1);
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h0);
    checkVal("state_after_rst", 32'(STATE), 32'd0);
    checkVal("epc_after_rst", EPC, 32'd0);
    idle(4);

    busy_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) busy_lvl = ~busy_lvl;
      applyStimulus(($urandom_range(0, 199) == 0), busy_lvl,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                    $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: EX/MEM/WB drain cycles before interrupt entry (range 1..7).
REQ-002 Parameter MEM_TIMEOUT, default 15: MEM_WAIT cycles before MEM_ERR is raised (range 2..255).
REQ-003 CLK  in  1  the only clock; all state updates on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 LW_STALL  in  1  load-use hazard from the hazard unit.
REQ-006 BR_TAKEN  in  1  branch/jump in EX redirects the PC.
REQ-007 MEM_BUSY  in  1  data memory not ready; the pipeline must freeze.
REQ-008 INTR, INTR_EN  in  1 each  pending interrupt (level) and global interrupt enable.
REQ-009 DEC_PC  in  32  PC of the instruction currently in DEC.
REQ-010 PC_WE, IF_DEC_WE, DEC_EX_WE, EX_MEM_WE, MEM_WB_WE  out  1 each  PC and pipeline-register write enables.
REQ-011 IF_FLUSH, DEC_FLUSH, EX_FLUSH  out  1 each  bubble into the IF/DEC, DEC/EX and EX/MEM registers respectively.
REQ-012 INTR_TAKEN  out  1  one-cycle pulse; PC loads the trap vector.
REQ-013 EPC  out  32  registered resume PC.  MEM_ERR  out  1  sticky timeout flag.  STATE  out  2  current state.

Function
REQ-014 States SHALL be RUN=0, MEM_WAIT=1, DRAIN=2, TRAP=3, with a 1-bit return register RET (RUN/DRAIN), a wait counter WCNT (8b) and a drain counter DCNT (3b).
REQ-015 Outputs SHALL be combinational from state and inputs; the defaults are all WE=1, all FLUSH=0, INTR_TAKEN=0.
REQ-016 RUN priority SHALL be MEM_BUSY > BR_TAKEN > LW_STALL > (INTR & INTR_EN).
REQ-017 RUN with MEM_BUSY=1: all WE=0, no flush; next MEM_WAIT, RET<=RUN, WCNT<=0.
REQ-018 RUN with BR_TAKEN=1: all WE=1, IF_FLUSH=1, DEC_FLUSH=1; remain in RUN.
REQ-019 RUN with LW_STALL=1: PC_WE=IF_DEC_WE=DEC_EX_WE=0, EX_FLUSH=1, EX_MEM_WE=MEM_WB_WE=1; remain in RUN (re-evaluated every cycle).
REQ-020 RUN with INTR&INTR_EN and no higher-priority event: PC_WE=0, IF_FLUSH=1, DEC_FLUSH=1; EPC<=DEC_PC, DCNT<=0; next DRAIN.
REQ-021 DRAIN, MEM_BUSY=0: PC_WE=0, IF_FLUSH=1, DEC_FLUSH=1, DCNT++; BR_TAKEN and LW_STALL ignored; if DCNT==DRAIN_CYCLES-1, next TRAP.
REQ-022 DRAIN, MEM_BUSY=1: all WE=0, no flush, DCNT held; next MEM_WAIT, RET<=DRAIN, WCNT<=0.
REQ-023 MEM_WAIT, MEM_BUSY=1: all WE=0, no flush; WCNT increments and saturates at 255; when WCNT==MEM_TIMEOUT-1, MEM_ERR<=1.
REQ-024 MEM_WAIT, MEM_BUSY=0: apply the RUN rules (without interrupt acceptance) if RET=RUN, or the DRAIN rules if RET=DRAIN; next state per those rules, otherwise RET.
REQ-025 TRAP: PC_WE=1, INTR_TAKEN=1, IF_FLUSH=1, DEC_FLUSH=1; MEM_BUSY and all hazards ignored; next RUN.
REQ-026 MEM_ERR SHALL stay 1 until RST; it does not alter sequencing.
REQ-027 EPC SHALL change only on interrupt acceptance (REQ-020).
REQ-028 STATE SHALL equal the registered state encoding.

Reset
REQ-029 When RST=1 at a clock edge: state<=RUN, RET<=RUN, WCNT<=0, DCNT<=0, EPC<=0, MEM_ERR<=0.
REQ-030 While RST=1: all WE=0, IF_FLUSH=DEC_FLUSH=EX_FLUSH=1, INTR_TAKEN=0, regardless of state or inputs.
REQ-031 A reset asserted mid-MEM_WAIT or mid-DRAIN SHALL abandon the sequence; no INTR_TAKEN pulse SHALL follow.

Verification
REQ-032 Post-reset idle, all inputs 0 -> all WE=1, flushes 0, STATE=0, EPC=0, MEM_ERR=0.
REQ-033 BR_TAKEN=1 and LW_STALL=1 in the same cycle in RUN -> IF_FLUSH=DEC_FLUSH=1, PC_WE=1, EX_FLUSH=0.
REQ-034 INTR=INTR_EN=1 with DEC_PC=0x00000120 -> 3 DRAIN cycles (PC_WE=0), then one TRAP cycle with INTR_TAKEN=1, then RUN; EPC=0x00000120.
REQ-035 MEM_BUSY held for 20 cycles from RUN -> all WE=0 for 20 cycles; MEM_ERR=1 after the 15th MEM_WAIT cycle; RUN resumes when MEM_BUSY=0 and MEM_ERR stays 1.
REQ-036 MEM_BUSY for 2 cycles during DRAIN cycle 2 -> DCNT held; DRAIN resumes; TRAP occurs after exactly 3 non-frozen DRAIN cycles.
REQ-037 RST pulsed during DRAIN -> STATE=0 next cycle; no INTR_TAKEN pulse; EPC=0.
